// File: rtl/memmap_ctrl.sv
// Address-decoding memory-map controller: routes one master request to one of
// NUM_REGIONS slaves with per-region wait states. Optional error counter under MEMMAP_ERRCNT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready; decode and latch an incoming request
// ST_WAIT   | slave selected; wait counter runs down to terminal count 0
// ST_RESP   | one-cycle response pulse (rsp_err set for decode/RO faults)
module memmap_ctrl #(
  parameter int NUM_REGIONS = 3,
  parameter int DATA_W      = 32,
  parameter logic [NUM_REGIONS*32-1:0] REGION_BASE  = {32'h801, 32'h400, 32'h000},
  parameter logic [NUM_REGIONS*32-1:0] REGION_LIMIT = {32'hFFFF_FFFF, 32'h800, 32'h3FF},
  parameter logic [NUM_REGIONS*4-1:0]  REGION_WAIT  = {4'd2, 4'd1, 4'd0},
  parameter logic [NUM_REGIONS-1:0]    REGION_RO    = 3'b010
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   DataAdr,
  input  logic                          MemWrite,
  input  logic [NUM_REGIONS*DATA_W-1:0] slave_rdata,
  output logic [NUM_REGIONS-1:0]        sel,
  output logic [NUM_REGIONS-1:0]        WE,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             ReadData,
  output logic                          rsp_err,
  output logic [15:0]                   err_count
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   hit_q, hit_d;
  logic               wr_q, wr_d;
  logic               err_q, err_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               dec_hit;
  logic               dec_ro;
  logic               dec_err;
  logic [IDX_W-1:0]   dec_idx;
  logic [3:0]         dec_wait;

  // Scan from the top index down so the lowest matching region wins.
  always_comb begin
    dec_hit  = 1'b0;
    dec_ro   = 1'b0;
    dec_idx  = '0;
    dec_wait = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (DataAdr >= REGION_BASE[i*32 +: 32] && DataAdr <= REGION_LIMIT[i*32 +: 32]) begin
        dec_hit  = 1'b1;
        dec_ro   = REGION_RO[i];
        dec_idx  = IDX_W'(i);
        dec_wait = REGION_WAIT[i*4 +: 4];
      end
    end
    dec_err = !dec_hit || (MemWrite && dec_ro);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hit_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    wr_d    = wr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          hit_d = dec_idx;
          wr_d  = MemWrite;
          err_d = dec_err;
          if (dec_err) begin
            state_d = ST_RESP;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = dec_wait;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          if (!wr_q) rdata_d = slave_rdata[int'(hit_q)*DATA_W +: DATA_W];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_err   = (state_q == ST_RESP) && err_q;
    sel       = '0;
    WE        = '0;
    if (state_q == ST_WAIT) begin
      sel = NUM_REGIONS'(1) << hit_q;
      if (cnt_q == 4'd0 && wr_q) WE = NUM_REGIONS'(1) << hit_q;
    end
  end

  assign ReadData = rdata_q;

`ifdef MEMMAP_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (rsp_valid && rsp_err && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_memmap_ctrl.sv
// Self-checking bench for memmap_ctrl: directed scenarios plus randomized accesses
// checked cycle-by-cycle against a region-table reference model.
module tb_memmap_ctrl;

  localparam int NR = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   DataAdr;
  logic          MemWrite;
  logic [95:0]   slave_rdata;
  logic [2:0]    sel;
  logic [2:0]    WE;
  logic          rsp_valid;
  logic [31:0]   ReadData;
  logic          rsp_err;
  logic [15:0]   err_count;

  memmap_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .DataAdr    (DataAdr),
    .MemWrite   (MemWrite),
    .slave_rdata(slave_rdata),
    .sel        (sel),
    .WE         (WE),
    .rsp_valid  (rsp_valid),
    .ReadData   (ReadData),
    .rsp_err    (rsp_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Reference memory map, written as plain tables.
  logic [31:0] ref_base  [NR] = '{32'h000, 32'h400, 32'h801};
  logic [31:0] ref_limit [NR] = '{32'h3FF, 32'h800, 32'hFFFF_FFFF};
  int          ref_wait  [NR] = '{0, 1, 2};
  bit          ref_ro    [NR] = '{1'b0, 1'b1, 1'b0};

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] rd_model = '0;
  int          ec_model = 0;

  function automatic int ref_region(input logic [31:0] addr);
    for (int r = 0; r < NR; r++)
      if (addr >= ref_base[r] && addr <= ref_limit[r]) return r;
    return -1;
  endfunction

  function automatic logic [15:0] ec_expected();
`ifdef MEMMAP_ERRCNT_EN
    return (ec_model > 65535) ? 16'hFFFF : 16'(ec_model);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge after the response.
  task automatic access(input logic [31:0] addr, input logic wr, input logic hold,
                        input logic [95:0] rdata);
    int r, lat;
    logic err;
    logic [2:0] exp_sel, exp_we;
    r   = ref_region(addr);
    err = (r < 0) || (wr && ref_ro[r]);
    lat = err ? 1 : ref_wait[r] + 2;
    DataAdr     = addr;
    MemWrite    = wr;
    slave_rdata = rdata;
    req_valid   = 1'b1;
    chk("ready_at_accept", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      exp_sel = (!err && k < lat) ? 3'(1 << r) : 3'b000;
      exp_we  = (wr && k == lat - 1) ? exp_sel : 3'b000;
      chk($sformatf("cyc%0d_adr%0h_wr%0d", k, addr, wr),
          64'({sel, WE, rsp_valid, rsp_err}),
          64'({exp_sel, exp_we, k == lat, err && k == lat}));
      if (k == lat) begin
        if (!err && !wr) rd_model = rdata[r*32 +: 32];
        if (err) ec_model++;
        chk($sformatf("rdata_adr%0h", addr), 64'(ReadData), 64'(rd_model));
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    chk("ready_after_rsp", 64'({req_ready, rsp_valid}), 64'b10);
    chk("err_count", 64'(err_count), 64'(ec_expected()));
  endtask

  initial begin
    logic [31:0] bnd [6];
    logic [31:0] a;
    bnd = '{32'h0, 32'h3FF, 32'h400, 32'h800, 32'h801, 32'hFFFF_FFFF};
    reset       = 1'b1;
    req_valid   = 1'b0;
    DataAdr     = '0;
    MemWrite    = 1'b0;
    slave_rdata = '0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({sel, WE, rsp_valid, rsp_err, req_ready}), 64'b000000001);
    chk("reset_rdata", 64'(ReadData), 64'd0);
    chk("reset_errcnt", 64'(err_count), 64'd0);
    reset = 1'b0;

    // Accept immediately after reset release: read 0x010 -> 0xCAFE.
    access(32'h010, 1'b0, 1'b0, {32'h1111_1111, 32'h2222_2222, 32'h0000_CAFE});
    access(32'h900, 1'b1, 1'b0, {$urandom, $urandom, $urandom});
    access(32'h400, 1'b1, 1'b0, {$urandom, $urandom, $urandom});
    access(32'h3FF, 1'b0, 1'b0, {$urandom, $urandom, $urandom});
    access(32'h400, 1'b0, 1'b0, {$urandom, $urandom, $urandom});
    access(32'h800, 1'b0, 1'b0, {$urandom, $urandom, $urandom});
    access(32'h801, 1'b0, 1'b0, {$urandom, $urandom, $urandom});

    // Back-to-back reads with req_valid held: second accept lands three edges later.
    access(32'h000, 1'b0, 1'b1, {$urandom, $urandom, $urandom});
    access(32'h000, 1'b0, 1'b0, {$urandom, $urandom, $urandom});
    @(negedge clk);
    chk("b2b_no_third_rsp", 64'({rsp_valid, sel}), 64'd0);

    // Reset during the second WAIT cycle of a write to 0x900.
    DataAdr   = 32'h900;
    MemWrite  = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_wait1", 64'({sel, WE}), 64'b100_000);
    @(negedge clk);
    chk("abort_wait2", 64'({sel, WE}), 64'b100_000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_model = '0;
    ec_model = 0;
    chk("abort_cleared", 64'({sel, WE, rsp_valid, rsp_err, req_ready}), 64'b000000001);
    chk("abort_rdata", 64'(ReadData), 64'd0);
    chk("abort_errcnt", 64'(err_count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet", 64'({WE, rsp_valid, req_ready}), 64'b000_0_1);
    end

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: a = $urandom_range(0, 32'h3FF);
        1: a = 32'h400 + $urandom_range(0, 32'h400);
        2: a = $urandom;
        3: a = bnd[$urandom_range(0, 5)];
        default: a = 32'h801 + $urandom_range(0, 15);
      endcase
      access(a, 1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
